multicycle_control: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath: one FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Shares a single memory port and a single ALU across those phases.
- Replaces the per-opcode combinational control unit once the datapath moves from single-cycle to multi-cycle.
- Drives the PC, IR, register-file, memory and ALU mux selects; stretches memory phases on a ready handshake.

---
 rtl/multicycle_control_pkg.sv | 82 ++++++++
 rtl/multicycle_control_decode.sv | 97 +++++++++
 rtl/multicycle_control.sv | 128 ++++++++++++
 tb/tb_multicycle_control.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
//   Shared MIPS constants for the multi-cycle control path: instruction
//   opcodes, FSM state encodings (4 bits, RESET=0 .. HALT=13), datapath mux
//   select codes and the control word driven by the decode sub-module.
//   No ports; imported by multicycle_control and multicycle_control_decode.
package multicycle_control_pkg;

    // Instruction opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // FSM states; the encoding is visible on the debug state port.
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    // ALU operation
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    // PC source
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Write register select
    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    // Write data select
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALU_B_RT      = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       invert_zero;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// multicycle_control_decode
//   Pure combinational map from FSM state, latched opcode and mem_ready to
//   the datapath control word. Unlisted fields of a state stay 0.
//   Ports:
//     state     in  current FSM state
//     op_q      in  opcode latched during DECODE
//     mem_ready in  memory handshake (only affects FETCH strobes)
//     ctrl      out control word
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: the whole word is cleared first so every path assigns every bit and no latch is inferred.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                // IR and PC+4 are captured only in the cycle the read completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                ctrl.alu_src_b = ALU_B_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALU_B_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.invert_zero   = (op_q == OP_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
                if (op_q == OP_JAL) begin
                    // PC already holds PC+4 from FETCH, so it is the link value.
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REG_DST_RA;
                    ctrl.mem_to_reg = M2R_PC;
                end
            end
            S_HALT:  ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle MIPS sequencer: steps each instruction through fetch,
//   decode, execute, memory and writeback, sharing one memory port and one
//   ALU. Memory phases stretch while mem_ready is low.
//   Optional build macro MULTICYCLE_CONTROL_RETIRE_COUNT_EN adds a 32-bit
//   retired-instruction counter on port retired.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     opcode[5:0]         instruction[31:26] from the IR
//     mem_ready           memory completes the current access this cycle
//     pc_write, pc_write_cond, invert_zero, iord, mem_read, mem_write,
//     ir_write, reg_dst[1:0], mem_to_reg[1:0], reg_write, alu_src_a,
//     alu_src_b[1:0], alu_op[1:0], pc_source[1:0]   datapath controls
//     state[3:0]          current FSM state (debug)
//     halted              FSM is in HALT
//     retired[31:0]       retired instruction count (optional)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        invert_zero,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
`ifdef MULTICYCLE_CONTROL_RETIRE_COUNT_EN
    output logic [31:0] retired,
`endif
    output logic        halted
);

    state_t     state_q;
    state_t     state_next;
    logic [5:0] op_q;
    ctrl_t      ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_next;
    end

    // Opcode is captured on the DECODE edge so later states ignore the IR port.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: only a handful of flops, so reset them; a real memory array would not be reset.
        if (!rst_n)                   op_q <= '0;
        else if (state_q == S_DECODE) op_q <= opcode;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:      state_next = S_MEM_ADDR;
                    OP_RTYPE:          state_next = S_EXEC_R;
                    OP_ADDI, OP_ORI:   state_next = S_EXEC_I;
                    OP_BEQ, OP_BNE:    state_next = S_BRANCH;
                    OP_J, OP_JAL:      state_next = S_JUMP;
                    default:           state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_next = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_EXEC_R:   state_next = S_R_WB;
            S_EXEC_I:   state_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_RESET;
        endcase
    end

    multicycle_control_decode u_decode (
        .state     (state_q),
        .op_q      (op_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

`ifdef MULTICYCLE_CONTROL_RETIRE_COUNT_EN
    // An instruction retires when its final state hands back to FETCH; the
    // illegal-as-NOP path (DECODE -> FETCH) is deliberately not counted.
    logic retire;
    assign retire = (state_next == S_FETCH) &&
                    (state_q inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired <= '0;
        else if (retire) retired <= retired + 32'd1;
    end
`endif

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign invert_zero   = ctrl.invert_zero;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign halted        = ctrl.halted;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Drives instructions into two copies of multicycle_control (illegal
//   opcodes halt / illegal opcodes act as NOP). A per-instruction model
//   expands each instruction into its expected cycle-by-cycle control
//   vectors (with randomized fetch and memory wait states and random
//   don't-care inputs) and queues them; one compare process checks every
//   cycle. Build with MULTICYCLE_CONTROL_RETIRE_COUNT_EN to also check retired.
module tb_multicycle_control;

    localparam logic [3:0] ST_RESET = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2,
                           ST_MEM_ADDR = 4'd3, ST_MEM_RD = 4'd4, ST_MEM_WB = 4'd5,
                           ST_MEM_WR = 4'd6, ST_EXEC_R = 4'd7, ST_R_WB = 4'd8,
                           ST_EXEC_I = 4'd9, ST_I_WB = 4'd10, ST_BRANCH = 4'd11,
                           ST_JUMP = 4'd12, ST_HALT = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0d, OP_LW = 6'h23,
                           OP_SW = 6'h2b, OP_ILL = 6'h3f;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       invert_zero;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [3:0] state;
        logic       halted;
    } obs_t;

    typedef struct {
        obs_t        o;
        logic [31:0] r;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;

    logic       d_pcw, d_pcwc, d_inv, d_iord, d_mrd, d_mwr, d_irw, d_rw, d_asa, d_halt;
    logic [1:0] d_rdst, d_m2r, d_asb, d_aop, d_psrc;
    logic [3:0] d_state;
    logic       n_pcw, n_pcwc, n_inv, n_iord, n_mrd, n_mwr, n_irw, n_rw, n_asa, n_halt;
    logic [1:0] n_rdst, n_m2r, n_asb, n_aop, n_psrc;
    logic [3:0] n_state;
`ifdef MULTICYCLE_CONTROL_RETIRE_COUNT_EN
    logic [31:0] d_retired, n_retired;
`endif

    obs_t d_obs, n_obs;
    assign d_obs = {d_pcw, d_pcwc, d_inv, d_iord, d_mrd, d_mwr, d_irw, d_rdst, d_m2r,
                    d_rw, d_asa, d_asb, d_aop, d_psrc, d_state, d_halt};
    assign n_obs = {n_pcw, n_pcwc, n_inv, n_iord, n_mrd, n_mwr, n_irw, n_rdst, n_m2r,
                    n_rw, n_asa, n_asb, n_aop, n_psrc, n_state, n_halt};

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(d_pcw), .pc_write_cond(d_pcwc), .invert_zero(d_inv), .iord(d_iord),
        .mem_read(d_mrd), .mem_write(d_mwr), .ir_write(d_irw), .reg_dst(d_rdst),
        .mem_to_reg(d_m2r), .reg_write(d_rw), .alu_src_a(d_asa), .alu_src_b(d_asb),
        .alu_op(d_aop), .pc_source(d_psrc), .state(d_state),
`ifdef MULTICYCLE_CONTROL_RETIRE_COUNT_EN
        .retired(d_retired),
`endif
        .halted(d_halt)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) u_nop (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(n_pcw), .pc_write_cond(n_pcwc), .invert_zero(n_inv), .iord(n_iord),
        .mem_read(n_mrd), .mem_write(n_mwr), .ir_write(n_irw), .reg_dst(n_rdst),
        .mem_to_reg(n_m2r), .reg_write(n_rw), .alu_src_a(n_asa), .alu_src_b(n_asb),
        .alu_op(n_aop), .pc_source(n_psrc), .state(n_state),
`ifdef MULTICYCLE_CONTROL_RETIRE_COUNT_EN
        .retired(n_retired),
`endif
        .halted(n_halt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        exp_q[$];
    logic [31:0] model_retired = '0;
    bit          nop_sync = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    function automatic obs_t idle(input logic [3:0] st);
        obs_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One compare process: every queued cycle is checked on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t ent;
            ent = exp_q.pop_front();
            check("dut_ctrl", 64'(d_obs), 64'(ent.o));
            if (nop_sync) check("nop_ctrl", 64'(n_obs), 64'(ent.o));
`ifdef MULTICYCLE_CONTROL_RETIRE_COUNT_EN
            check("dut_retired", 64'(d_retired), 64'(ent.r));
`endif
        end
    end

    // Called at posedge+1: drive this cycle's inputs, queue its expectation.
    task automatic step(input logic [5:0] op, input logic rdy, input obs_t e);
        opcode    = op;
        mem_ready = rdy;
        exp_q.push_back('{o: e, r: model_retired});
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_assert_dut", 64'(d_obs), 64'd0);
        check("rst_assert_nop", 64'(n_obs), 64'd0);
`ifdef MULTICYCLE_CONTROL_RETIRE_COUNT_EN
        check("rst_assert_retired", 64'(d_retired), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_dut", 64'(d_obs), 64'd0);
        rst_n         = 1'b1;
        model_retired = '0;
        nop_sync      = 1'b1;
        step(rnd_op(), rnd_bit(), idle(ST_RESET));
    endtask

    // Expands one instruction into its expected per-cycle control vectors.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input bit abort, output int cycles);
        obs_t e;
        cycles = 0;
        for (int i = 0; i <= fw; i++) begin
            e = idle(ST_FETCH);
            e.mem_read  = 1'b1;
            e.alu_src_b = 2'b01;
            if (i == fw) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            step(rnd_op(), (i == fw), e);
            cycles++;
        end
        e = idle(ST_DECODE);
        e.alu_src_b = 2'b11;
        step(op, rnd_bit(), e);
        cycles++;

        if (op == OP_LW || op == OP_SW) begin
            e = idle(ST_MEM_ADDR);
            e.alu_src_a = 1'b1;
            e.alu_src_b = 2'b10;
            step(rnd_op(), rnd_bit(), e);
            cycles++;
            e = idle((op == OP_LW) ? ST_MEM_RD : ST_MEM_WR);
            e.iord = 1'b1;
            if (op == OP_LW) e.mem_read = 1'b1;
            else             e.mem_write = 1'b1;
            for (int i = 0; i <= mw; i++) begin
                if (abort && i == mw) begin
                    opcode    = rnd_op();
                    mem_ready = 1'b0;
                    check("abort_in_memrd", 64'(d_state), 64'(ST_MEM_RD));
                    #2;
                    apply_reset();
                    return;
                end
                step(rnd_op(), (i == mw), e);
                cycles++;
            end
            if (op == OP_LW) begin
                e = idle(ST_MEM_WB);
                e.reg_write  = 1'b1;
                e.mem_to_reg = 2'b01;
                step(rnd_op(), rnd_bit(), e);
                cycles++;
            end
        end else if (op == OP_RTYPE) begin
            e = idle(ST_EXEC_R);
            e.alu_src_a = 1'b1;
            e.alu_op    = 2'b10;
            step(rnd_op(), rnd_bit(), e);
            e = idle(ST_R_WB);
            e.reg_write = 1'b1;
            e.reg_dst   = 2'b01;
            step(rnd_op(), rnd_bit(), e);
            cycles += 2;
        end else if (op == OP_ADDI || op == OP_ORI) begin
            e = idle(ST_EXEC_I);
            e.alu_src_a = 1'b1;
            e.alu_src_b = 2'b10;
            e.alu_op    = (op == OP_ORI) ? 2'b11 : 2'b00;
            step(rnd_op(), rnd_bit(), e);
            e = idle(ST_I_WB);
            e.reg_write = 1'b1;
            step(rnd_op(), rnd_bit(), e);
            cycles += 2;
        end else if (op == OP_BEQ || op == OP_BNE) begin
            e = idle(ST_BRANCH);
            e.alu_src_a     = 1'b1;
            e.alu_op        = 2'b01;
            e.pc_write_cond = 1'b1;
            e.pc_source     = 2'b01;
            e.invert_zero   = (op == OP_BNE);
            step(rnd_op(), rnd_bit(), e);
            cycles++;
        end else if (op == OP_J || op == OP_JAL) begin
            e = idle(ST_JUMP);
            e.pc_write  = 1'b1;
            e.pc_source = 2'b10;
            if (op == OP_JAL) begin
                e.reg_write  = 1'b1;
                e.reg_dst    = 2'b10;
                e.mem_to_reg = 2'b10;
            end
            step(rnd_op(), rnd_bit(), e);
            cycles++;
        end else begin
            // Illegal: the NOP build is already back in FETCH, the halting build sticks.
            nop_sync = 1'b0;
            check("nop_illegal_state", 64'(n_state), 64'(ST_FETCH));
            check("nop_illegal_halted", 64'(n_halt), 64'd0);
            for (int i = 0; i < 100; i++) begin
                e = idle(ST_HALT);
                e.halted = 1'b1;
                step(rnd_op(), rnd_bit(), e);
                cycles++;
            end
            return;
        end
        model_retired = model_retired + 32'd1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          c;
        logic [5:0]  legal [9];
        legal = '{OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW};

        @(posedge clk);
        #1;
        apply_reset();

        // ADD, LW with two stall cycles, J from reset: latencies and retire count.
        run_instr(OP_RTYPE, 0, 0, 1'b0, c);
        check("lat_add", 64'(c), 64'd4);
        check("add_back_in_fetch", 64'(d_state), 64'(ST_FETCH));
        run_instr(OP_LW, 0, 2, 1'b0, c);
        check("lat_lw_stall2", 64'(c), 64'd7);
        run_instr(OP_J, 0, 0, 1'b0, c);
        check("lat_j", 64'(c), 64'd3);
`ifdef MULTICYCLE_CONTROL_RETIRE_COUNT_EN
        check("retired_after_3", 64'(d_retired), 64'd3);
`endif

        run_instr(OP_BNE, 0, 0, 1'b0, c);
        check("lat_bne", 64'(c), 64'd3);
        run_instr(OP_BEQ, 1, 0, 1'b0, c);
        check("lat_beq_fetch_wait", 64'(c), 64'd4);
        run_instr(OP_JAL, 0, 0, 1'b0, c);
        check("lat_jal", 64'(c), 64'd3);
        run_instr(OP_SW, 0, 1, 1'b0, c);
        check("lat_sw_stall1", 64'(c), 64'd5);
        run_instr(OP_ADDI, 0, 0, 1'b0, c);
        check("lat_addi", 64'(c), 64'd4);
        run_instr(OP_ORI, 0, 0, 1'b0, c);
        check("lat_ori", 64'(c), 64'd4);
        check("ori_back_in_fetch", 64'(d_state), 64'(ST_FETCH));

        // Reset in the middle of a stalled LW read.
        run_instr(OP_LW, 0, 1, 1'b1, c);
        run_instr(OP_RTYPE, 0, 0, 1'b0, c);

        // Illegal opcode: halting build stays in HALT for 100 cycles.
        run_instr(OP_ILL, 0, 0, 1'b0, c);
        check("halt_still_halted", 64'(d_halt), 64'd1);
        apply_reset();

        // Randomized instruction stream with random wait states.
        for (int i = 0; i < 200; i++) begin
            run_instr(legal[$urandom_range(0, 8)], $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'b0, c);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
